// File: rtl/fifo_rd_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rd_arbiter
//   Round-robin read scheduler that shares one consumer among NUM_CH
//   async-FIFO read ports, in the read clock domain. Each cycle it pops at
//   most one FIFO that is both non-empty and enabled. The popped word and
//   its channel ID are registered into a single valid/ready output stage.
//
// Ports
//   r_clk      read-domain clock, rising edge
//   r_rst_n    asynchronous active-low reset
//   r_empty    per-FIFO empty flag, bit k = FIFO k
//   r_data     per-FIFO read data, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ch_en      per-channel enable, 0 = channel never granted
//   r_inc      one-hot pop strobe to each FIFO's read pointer
//   out_data   registered popped word
//   out_ch     channel ID of out_data
//   out_valid  out_data/out_ch hold a word
//   out_ready  consumer accepts when out_valid & out_ready
// ---------------------------------------------------------------------------
module fifo_rd_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         r_clk,
  input  logic                         r_rst_n,
  input  logic [NUM_CH-1:0]            r_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] r_data,
  input  logic [NUM_CH-1:0]            ch_en,
  output logic [NUM_CH-1:0]            r_inc,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [NUM_CH-1:0]     eligible;
  logic                  slotFree;
  logic                  grantValid;
  logic [CH_W-1:0]       grantIdx;
  logic [CH_W:0]         cand;
  logic [DATA_WIDTH-1:0] grantData;

  logic [CH_W-1:0]       rrPtr_q, rrPtr_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic [CH_W-1:0]       outCh_q, outCh_d;
  logic                  outValid_q, outValid_d;

  // A channel may be popped only if its FIFO reports data and it is enabled.
  // The empty flag is trusted as-is, even when it lags the write side, so a
  // just-popped FIFO waits for its own flag to re-evaluate before it can win
  // again. The output slot is free when empty or being drained this cycle,
  // which is what lets a new word load on the same edge as an accept.
  always_comb begin
    eligible = ~r_empty & ch_en;
    slotFree = ~outValid_q | out_ready;
  end

  // Round-robin search starting at rrPtr_q and wrapping modulo NUM_CH; the
  // first eligible channel found wins. The candidate index is kept one bit
  // wider so the wrap works for channel counts that are not a power of two.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rrPtr_q} + (CH_W+1)'(i);
      if (cand >= (CH_W+1)'(NUM_CH)) begin
        cand = cand - (CH_W+1)'(NUM_CH);
      end
      if (!grantValid && eligible[cand[CH_W-1:0]]) begin
        grantValid = 1'b1;
        grantIdx   = cand[CH_W-1:0];
      end
    end
    if (!slotFree) begin
      grantValid = 1'b0;
    end
  end

  // The pop strobe is gated by reset directly so that no FIFO is ever
  // popped while the arbiter is held in reset, whatever the inputs do.
  always_comb begin
    r_inc = '0;
    if (grantValid && r_rst_n) begin
      r_inc[grantIdx] = 1'b1;
    end
  end

  // Steer the granted FIFO's read word toward the output register.
  always_comb begin
    grantData = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grantIdx == CH_W'(k)) begin
        grantData = r_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state for the output stage and the round-robin pointer. A grant
  // loads a fresh word and moves the pointer just past the winner. Without a
  // grant the word drains on acceptance or holds stable under backpressure,
  // and the pointer holds.
  always_comb begin
    rrPtr_d    = rrPtr_q;
    outData_d  = outData_q;
    outCh_d    = outCh_q;
    outValid_d = outValid_q & ~out_ready;
    if (grantValid) begin
      outData_d  = grantData;
      outCh_d    = grantIdx;
      outValid_d = 1'b1;
      rrPtr_d    = (grantIdx == CH_W'(NUM_CH-1)) ? '0 : grantIdx + CH_W'(1);
    end
  end

  // State registers. Reset discards any word still held in the output,
  // since it has already been popped from its FIFO.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      rrPtr_q    <= '0;
      outData_q  <= '0;
      outCh_q    <= '0;
      outValid_q <= 1'b0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      outData_q  <= outData_d;
      outCh_q    <= outCh_d;
      outValid_q <= outValid_d;
    end
  end

  always_comb begin
    out_data  = outData_q;
    out_ch    = outCh_q;
    out_valid = outValid_q;
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_arbiter
//   Directed bench for fifo_rd_arbiter with four channels of byte data.
//   Each FIFO is modelled by a read and a write index; the word at index n
//   of channel k is k*64+n, so every expected word is known up front.
// ---------------------------------------------------------------------------
module tb_fifo_rd_arbiter;

  logic        r_clk;
  logic        r_rst_n;
  logic [3:0]  r_empty;
  logic [31:0] r_data;
  logic [3:0]  ch_en;
  logic [3:0]  r_inc;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  int rdPtr [4];
  int wrPtr [4];
  int checks;
  int errors;

  fifo_rd_arbiter #(
    .NUM_CH     (4),
    .CH_W       (2),
    .DATA_WIDTH (8)
  ) dut (
    .r_clk     (r_clk),
    .r_rst_n   (r_rst_n),
    .r_empty   (r_empty),
    .r_data    (r_data),
    .ch_en     (ch_en),
    .r_inc     (r_inc),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running read clock, 10 time units per period.
  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  function automatic logic [7:0] word(input int k, input int idx);
    return 8'((k * 64) + idx);
  endfunction

  // FIFO model: empty when read index meets write index, data is the word
  // at the current read index.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      r_empty[k]         = (rdPtr[k] == wrPtr[k]);
      r_data[k*8 +: 8]   = word(k, rdPtr[k]);
    end
  end

  // Each pop strobe advances that FIFO's read index.
  always @(posedge r_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (r_inc[k]) rdPtr[k] <= rdPtr[k] + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic rdy);
    ch_en     = en;
    out_ready = rdy;
  endtask

  task automatic tickCycle();
    @(posedge r_clk);
    #1;
  endtask

  task automatic checkWord(input string tag, input int ch, input int idx);
    checkOutput($sformatf("%s valid", tag), 32'(out_valid), 32'd1);
    checkOutput($sformatf("%s ch", tag), 32'(out_ch), 32'(ch));
    checkOutput($sformatf("%s data", tag), 32'(out_data), 32'(word(ch, idx)));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    r_rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rdPtr[k] = 0;
      wrPtr[k] = 3;
    end
    applyStimulus(4'b1111, 1'b1);

    // Reset with everything eligible: no pops, empty output.
    #2;
    checkOutput("reset r_inc", 32'(r_inc), 32'h0);
    checkOutput("reset valid", 32'(out_valid), 32'h0);
    checkOutput("reset ch", 32'(out_ch), 32'h0);
    checkOutput("reset data", 32'(out_data), 32'h0);
    tickCycle();
    tickCycle();
    checkOutput("reset hold r_inc", 32'(r_inc), 32'h0);
    checkOutput("reset hold rdPtr0", 32'(rdPtr[0]), 32'd0);
    r_rst_n = 1'b1;
    #1;
    checkOutput("first grant", 32'(r_inc), 32'b0001);

    // Round robin over four 3-deep FIFOs, back-to-back.
    for (int i = 0; i < 12; i++) begin
      tickCycle();
      checkWord($sformatf("rr%0d", i), i % 4, i / 4);
    end
    tickCycle();
    checkOutput("rr drained valid", 32'(out_valid), 32'h0);
    checkOutput("rr drained r_inc", 32'(r_inc), 32'h0);

    // Skip empty channels 1 and 3.
    wrPtr[0] = wrPtr[0] + 3;
    wrPtr[2] = wrPtr[2] + 3;
    #1;
    checkOutput("skip first r_inc", 32'(r_inc), 32'b0001);
    for (int j = 0; j < 6; j++) begin
      tickCycle();
      checkWord($sformatf("skip%0d", j), (j % 2) * 2, 3 + j / 2);
      checkOutput($sformatf("skip%0d odd r_inc", j), 32'(r_inc & 4'b1010), 32'h0);
    end

    // Backpressure for five cycles, then release.
    applyStimulus(4'b1111, 1'b0);
    wrPtr[1] = wrPtr[1] + 2;
    #1;
    checkOutput("bp r_inc", 32'(r_inc), 32'h0);
    for (int j = 0; j < 5; j++) begin
      tickCycle();
      checkOutput($sformatf("bp%0d r_inc", j), 32'(r_inc), 32'h0);
      checkWord($sformatf("bp%0d", j), 2, 5);
    end
    applyStimulus(4'b1111, 1'b1);
    #1;
    checkOutput("bp release r_inc", 32'(r_inc), 32'b0010);
    tickCycle();
    checkWord("bp word0", 1, 3);
    tickCycle();
    checkWord("bp word1", 1, 4);
    tickCycle();
    checkOutput("bp drained valid", 32'(out_valid), 32'h0);

    // Only channel 2 enabled, then everything disabled with a word held.
    for (int k = 0; k < 4; k++) wrPtr[k] = wrPtr[k] + 2;
    applyStimulus(4'b0100, 1'b1);
    #1;
    checkOutput("en r_inc", 32'(r_inc), 32'b0100);
    tickCycle();
    checkWord("en word", 2, 6);
    checkOutput("en r_inc again", 32'(r_inc), 32'b0100);
    applyStimulus(4'b0000, 1'b0);
    #1;
    checkOutput("en off r_inc", 32'(r_inc), 32'h0);
    tickCycle();
    checkWord("en held", 2, 6);
    applyStimulus(4'b0000, 1'b1);
    #1;
    checkOutput("en off accept r_inc", 32'(r_inc), 32'h0);
    tickCycle();
    checkOutput("en drained valid", 32'(out_valid), 32'h0);

    // Grant channel 3 so the pointer wraps, then reset mid-cycle.
    applyStimulus(4'b1111, 1'b1);
    #1;
    checkOutput("wrap r_inc", 32'(r_inc), 32'b1000);
    tickCycle();
    checkWord("wrap word", 3, 3);
    checkOutput("wrap next r_inc", 32'(r_inc), 32'b0001);
    #2;
    r_rst_n = 1'b0;
    #1;
    checkOutput("midrst valid", 32'(out_valid), 32'h0);
    checkOutput("midrst r_inc", 32'(r_inc), 32'h0);
    checkOutput("midrst ch", 32'(out_ch), 32'h0);
    checkOutput("midrst data", 32'(out_data), 32'h0);
    tickCycle();
    checkOutput("midrst hold r_inc", 32'(r_inc), 32'h0);
    checkOutput("midrst rdPtr0", 32'(rdPtr[0]), 32'd6);
    r_rst_n = 1'b1;
    #1;
    checkOutput("post rst r_inc", 32'(r_inc), 32'b0001);
    tickCycle();
    checkWord("post rst word", 0, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
